// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg : shared state encoding, defaults and lane helpers for the feeder
// Rev 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_N    = 4;
  localparam int DEF_DW   = 8;
  localparam int DEF_KMAX = 16;

  // Low bit of lane `lane` in a packed bus of `dw`-wide lanes.
  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

  // Stream/drain counter must reach KMAX+N-2.
  function automatic int cnt_width(input int n, input int kmax);
    return $clog2(kmax + n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_bank.sv
// ============================================================================
// feeder_bank : N x KMAX operand register file with diagonally skewed read
// Rev 1.0
// ============================================================================
`default_nettype none

module feeder_bank
  import systolic_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int DW   = DEF_DW,
  parameter int KMAX = DEF_KMAX,
  parameter int CW   = cnt_width(DEF_N, DEF_KMAX)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [$clog2(N)-1:0]      wr_idx_i,
  input  logic [$clog2(KMAX)-1:0]   wr_k_i,
  input  logic [DW-1:0]             wr_data_i,
  input  logic [CW-1:0]             t_i,
  input  logic [$clog2(KMAX):0]     k_eff_i,
  output logic [N*DW-1:0]           rd_bus_o
);

  localparam int KW = $clog2(KMAX);

  logic [DW-1:0] mem_q [N][KMAX];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < KMAX; k++) begin
          mem_q[r][k] <= '0;
        end
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i][wr_k_i] <= wr_data_i;
    end
  end

  // Lane r reads element t-r; anything outside [0, k_eff) is zero padding.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [CW-1:0] rel;
    logic          in_win;
    assign rel    = t_i - CW'(r);
    assign in_win = (t_i >= CW'(r)) && (rel < CW'(k_eff_i));
    assign rd_bus_o[lane_lo(r, DW) +: DW] = in_win ? mem_q[r][rel[KW-1:0]] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder : skewed din/win edge driver for an NxN systolic MAC array;
// SYSTOLIC_FEEDER_CNT_EN adds a 16-bit completed-run counter (run_cnt_o).
// Rev 1.0
// ============================================================================
`default_nettype none

module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int DW   = DEF_DW,
  parameter int KMAX = DEF_KMAX
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic                      wr_sel_i,
  input  logic [$clog2(N)-1:0]      wr_idx_i,
  input  logic [$clog2(KMAX)-1:0]   wr_k_i,
  input  logic [DW-1:0]             wr_data_i,
  output logic                      wr_drop_o,
  input  logic                      start_i,
  input  logic [$clog2(KMAX):0]     k_len_i,
  output logic                      acc_clr_o,
  output logic [N*DW-1:0]           din_bus_o,
  output logic [N*DW-1:0]           win_bus_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef SYSTOLIC_FEEDER_CNT_EN
  ,
  output logic [15:0]               run_cnt_o
`endif
);

  localparam int KW = $clog2(KMAX);
  localparam int CW = cnt_width(N, KMAX);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW:0]   keff_q, keff_d;

  logic          wr_range_ok, wr_ok, wr_drop_d;
  logic [N*DW-1:0] a_rd, w_rd;

  logic            acc_clr_q, busy_q, done_q, wr_drop_q;
  logic [N*DW-1:0] din_q, win_q;

  assign wr_range_ok = (int'(wr_idx_i) < N) && (int'(wr_k_i) < KMAX);
  assign wr_ok       = wr_en_i && (state_q == ST_IDLE) && wr_range_ok;
  assign wr_drop_d   = wr_en_i && !wr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    keff_d  = keff_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && (k_len_i != '0)) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          keff_d  = (int'(k_len_i) > KMAX) ? (KW+1)'(KMAX) : k_len_i;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
        cnt_d   = '0;
      end
      ST_STREAM: begin
        if (cnt_q == CW'(keff_q) + CW'(N - 2)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Banks are read with the next-state index so lanes land in registers aligned with state.
  feeder_bank #(.N(N), .DW(DW), .KMAX(KMAX), .CW(CW)) u_bank_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_ok && !wr_sel_i),
    .wr_idx_i  (wr_idx_i),
    .wr_k_i    (wr_k_i),
    .wr_data_i (wr_data_i),
    .t_i       (cnt_d),
    .k_eff_i   (keff_d),
    .rd_bus_o  (a_rd)
  );

  feeder_bank #(.N(N), .DW(DW), .KMAX(KMAX), .CW(CW)) u_bank_w (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_ok && wr_sel_i),
    .wr_idx_i  (wr_idx_i),
    .wr_k_i    (wr_k_i),
    .wr_data_i (wr_data_i),
    .t_i       (cnt_d),
    .k_eff_i   (keff_d),
    .rd_bus_o  (w_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      keff_q    <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      din_q     <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      keff_q    <= keff_d;
      acc_clr_q <= (state_d == ST_CLEAR);
      busy_q    <= (state_d == ST_CLEAR) || (state_d == ST_STREAM) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
      wr_drop_q <= wr_drop_d;
      din_q     <= (state_d == ST_STREAM) ? a_rd : '0;
      win_q     <= (state_d == ST_STREAM) ? w_rd : '0;
    end
  end

  assign acc_clr_o = acc_clr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wr_drop_o = wr_drop_q;
  assign din_bus_o = din_q;
  assign win_bus_o = win_q;

`ifdef SYSTOLIC_FEEDER_CNT_EN
  logic [15:0] run_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_q <= '0;
    end else if (done_q) begin
      run_cnt_q <= run_cnt_q + 16'd1;
    end
  end

  assign run_cnt_o = run_cnt_q;
`endif

endmodule

`default_nettype wire
